// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path:
// FSM states, opcodes, ALU op selects, PC source selects, op classes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic r;
    logic iarith;
    logic ilogic;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle FSM (master)
// and the datapath it steers (slave).
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       instr_op_i;
  logic             zero_i;
  logic             mem_ready_i;
  logic             mem_req_o;
  logic             mem_we_o;
  logic             mem_src_o;
  logic             ir_write_o;
  logic             pc_write_o;
  logic [1:0]       pc_src_o;
  logic             extend_o;
  logic             alu_src_o;
  logic [1:0]       alu_op_o;
  logic             reg_dst_o;
  logic             mem_to_reg_o;
  logic             reg_write_o;
  logic             illegal_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] retired_o;

  modport master (
    input  instr_op_i, zero_i, mem_ready_i,
    output mem_req_o, mem_we_o, mem_src_o,
    output ir_write_o, pc_write_o, pc_src_o,
    output extend_o, alu_src_o, alu_op_o,
    output reg_dst_o, mem_to_reg_o, reg_write_o,
    output illegal_o, state_o, retired_o
  );

  modport slave (
    output instr_op_i, zero_i, mem_ready_i,
    input  mem_req_o, mem_we_o, mem_src_o,
    input  ir_write_o, pc_write_o, pc_src_o,
    input  extend_o, alu_src_o, alu_op_o,
    input  reg_dst_o, mem_to_reg_o, reg_write_o,
    input  illegal_o, state_o, retired_o
  );
endinterface

// File: rtl/multicycle_ctrl_op_class_decode.sv
// Opcode to one-hot instruction class, plus immediate
// extender mode (1 = sign, 0 = zero).
module op_class_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  output op_class_t  o_cls,
  output logic       o_ext
);

  always_comb begin
    o_cls = '0;
    o_ext = 1'b0;
    unique case (i_op)
      OP_R:    o_cls.r = 1'b1;
      OP_ADDI,
      OP_SLTI: begin
        o_cls.iarith = 1'b1;
        o_ext        = 1'b1;
      end
      OP_ANDI,
      OP_ORI,
      OP_LUI:  o_cls.ilogic = 1'b1;
      OP_LW: begin
        o_cls.lw = 1'b1;
        o_ext    = 1'b1;
      end
      OP_SW: begin
        o_cls.sw = 1'b1;
        o_ext    = 1'b1;
      end
      OP_BEQ: begin
        o_cls.beq = 1'b1;
        o_ext     = 1'b1;
      end
      OP_BNE: begin
        o_cls.bne = 1'b1;
        o_ext     = 1'b1;
      end
      OP_J:    o_cls.j = 1'b1;
      default: o_cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB control FSM with Moore decodes
// and a retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  multicycle_ctrl_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_op;
  logic [CNT_W-1:0] r_retired;

  logic [5:0]  w_cur_op;
  op_class_t   w_cls;
  logic        w_ext;
  logic        w_retire;
  logic        w_mem_req;
  logic        w_mem_we;
  logic        w_mem_src;
  logic        w_ir_write;
  logic        w_pc_write;
  logic [1:0]  w_pc_src;
  logic        w_extend;
  logic        w_alu_src;
  logic [1:0]  w_alu_op;
  logic        w_reg_dst;
  logic        w_mem_to_reg;
  logic        w_reg_write;
  logic        w_illegal;

  // The IR is only guaranteed live in ID; later states use the latched copy
  assign w_cur_op = (r_state == S_ID) ? bus.instr_op_i : r_op;

  op_class_decode u_dec (
    .i_op  (w_cur_op),
    .o_cls (w_cls),
    .o_ext (w_ext)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IF;
      r_op      <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ID)
        r_op <= bus.instr_op_i;
      if (w_retire)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = PC_PLUS4;
    w_extend     = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_op     = ALU_ADD;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    unique case (r_state)
      S_IF: begin
        w_mem_req = 1'b1;
        if (bus.mem_ready_i) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_ID;
        end
      end
      S_ID: begin
        w_extend = w_ext;
        unique case (1'b1)
          w_cls.j: begin
            w_pc_write = 1'b1;
            w_pc_src   = PC_JUMP;
            w_next     = S_IF;
            w_retire   = 1'b1;
          end
          w_cls.illegal: begin
            w_illegal = 1'b1;
            w_next    = S_IF;
          end
          default: w_next = S_EX;
        endcase
      end
      S_EX: begin
        w_extend = w_ext;
        unique case (1'b1)
          w_cls.r: begin
            w_alu_op = ALU_FUNCT;
            w_next   = S_WB;
          end
          w_cls.iarith: begin
            w_alu_src = 1'b1;
            w_next    = S_WB;
          end
          w_cls.ilogic: begin
            w_alu_src = 1'b1;
            w_alu_op  = ALU_IMM;
            w_next    = S_WB;
          end
          w_cls.lw, w_cls.sw: begin
            w_alu_src = 1'b1;
            w_next    = S_MEM;
          end
          w_cls.beq, w_cls.bne: begin
            w_alu_op   = ALU_SUB;
            w_pc_src   = PC_BRANCH;
            w_pc_write = bus.zero_i ^ w_cls.bne;
            w_next     = S_IF;
            w_retire   = 1'b1;
          end
          default: w_next = S_IF;
        endcase
      end
      S_MEM: begin
        w_extend  = w_ext;
        w_mem_req = 1'b1;
        w_mem_src = 1'b1;
        w_mem_we  = w_cls.sw;
        if (bus.mem_ready_i) begin
          if (w_cls.lw) begin
            w_next = S_WB;
          end else begin
            w_next   = S_IF;
            w_retire = 1'b1;
          end
        end
      end
      S_WB: begin
        w_extend     = w_ext;
        w_reg_write  = 1'b1;
        w_reg_dst    = w_cls.r;
        w_mem_to_reg = w_cls.lw;
        w_next       = S_IF;
        w_retire     = 1'b1;
      end
      default: w_next = S_IF;
    endcase
  end

  // Async reset must silence the datapath controls immediately
  assign bus.mem_req_o    = w_mem_req & rst_i;
  assign bus.mem_we_o     = w_mem_we & rst_i;
  assign bus.mem_src_o    = w_mem_src & rst_i;
  assign bus.ir_write_o   = w_ir_write & rst_i;
  assign bus.pc_write_o   = w_pc_write & rst_i;
  assign bus.pc_src_o     = w_pc_src & {2{rst_i}};
  assign bus.extend_o     = w_extend & rst_i;
  assign bus.alu_src_o    = w_alu_src & rst_i;
  assign bus.alu_op_o     = w_alu_op & {2{rst_i}};
  assign bus.reg_dst_o    = w_reg_dst & rst_i;
  assign bus.mem_to_reg_o = w_mem_to_reg & rst_i;
  assign bus.reg_write_o  = w_reg_write & rst_i;
  assign bus.illegal_o    = w_illegal & rst_i;
  assign bus.state_o      = r_state;
  assign bus.retired_o    = r_retired;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the single-issue MIPS-subset CPU.
- Sequences fetch, decode, execute, memory and writeback over a shared ALU and a shared instruction/data memory port.
- Drives the immediate extender's mode select (`extend_o`: 1 = sign, 0 = zero), the ALU operand and operation selects, PC update, and register-file and memory enables.
- Also keeps a retired-instruction counter for the lab benches.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- instr_op_i  in  6  opcode field of the instruction register; valid from the ID state onward
- zero_i  in  1  ALU zero flag; valid in EX
- mem_ready_i  in  1  memory completion strobe; may be held high
- mem_req_o  out  1  memory access request
- mem_we_o  out  1  memory write enable; qualified by mem_req_o
- mem_src_o  out  1  memory address select: 0 = PC, 1 = ALU result
- ir_write_o  out  1  load the instruction register
- pc_write_o  out  1  update the PC
- pc_src_o  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target
- extend_o  out  1  immediate extender mode: 1 = sign, 0 = zero
- alu_src_o  out  1  ALU operand B: 0 = register, 1 = extended immediate
- alu_op_o  out  2  ALU operation: 00 = add, 01 = sub, 10 = R-type funct, 11 = immediate logic/lui by opcode
- reg_dst_o  out  1  destination register: 1 = rd, 0 = rt
- mem_to_reg_o  out  1  writeback source: 1 = memory, 0 = ALU
- reg_write_o  out  1  register-file write enable
- illegal_o  out  1  one-cycle pulse on an undecodable opcode
- state_o  out  3  current state, for debug
- retired_o  out  CNT_W  count of completed legal instructions

Behaviour:
- State encoding: IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4. Encodings 5–7 are unreachable; if entered, the next state is IF and all enables are 0.
- Reset (rst_i = 0, asynchronous):
  - state = IF, op_q = 0, retired_o = 0.
  - While rst_i = 0, every output except state_o and retired_o is forced to 0.
- Outputs are Moore-style decodes of the state and the current opcode; every output not listed for a state is 0.
  - Current opcode = instr_op_i in ID, op_q in all other states.
  - op_q is loaded from instr_op_i on the ID exit edge.
- IF:
  - mem_req_o = 1, mem_src_o = 0.
  - When mem_ready_i = 1: ir_write_o = 1, pc_write_o = 1, pc_src_o = 00, and the next state is ID. Otherwise stay in IF (unbounded wait).
- ID:
  - Opcode classes: R = 0x00; I-arith = addi 0x08, slti 0x0A; I-logic = andi 0x0C, ori 0x0D, lui 0x0F; lw = 0x23; sw = 0x2B; beq = 0x04; bne = 0x05; j = 0x02.
  - j: pc_write_o = 1, pc_src_o = 10, next state IF, retire.
  - Unlisted opcode: illegal_o = 1 for exactly one cycle, next state IF, no retire, no writes.
  - All other classes: next state EX.
- extend_o:
  - 1 for addi, slti, lw, sw, beq, bne.
  - 0 for andi, ori, lui, R-type and j.
  - Valid in ID and EX, and held stable through MEM and WB.
- EX:
  - R: alu_src_o = 0, alu_op_o = 10, next state WB.
  - I-arith: alu_src_o = 1, alu_op_o = 00, next state WB. slti is resolved by the ALU decoder from the opcode.
  - I-logic: alu_src_o = 1, alu_op_o = 11, next state WB.
  - lw/sw: alu_src_o = 1, alu_op_o = 00, next state MEM.
  - beq/bne: alu_src_o = 0, alu_op_o = 01, pc_src_o = 01, pc_write_o = zero_i XOR (op == bne), next state IF, retire.
- MEM:
  - mem_req_o = 1, mem_src_o = 1, mem_we_o = (op == sw).
  - Hold all of these until mem_ready_i = 1.
  - On mem_ready_i: lw goes to WB; sw goes to IF and retires.
- WB:
  - reg_write_o = 1, reg_dst_o = (op == R), mem_to_reg_o = (op == lw).
  - Next state IF, retire.
- Retire: retired_o increments by 1 on the edge of a retiring transition and wraps to 0 after all-ones.
- Latency with zero-wait memory:
  - j = 2 cycles; beq/bne = 3; R, I-type and sw = 4; lw = 5.
  - Each cycle mem_ready_i stays low adds one cycle in IF or MEM.
- Reset asserted mid-instruction aborts it immediately, with no retire and no partial register write. After release, fetch restarts in IF on the first rising edge.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encodings;
  - opcode constants;
  - alu_op encodings;
  - pc_src encodings.
- The datapath mux decoders import the same package.
- Sub-module op_class_decode: combinational, takes the 6-bit opcode and outputs a one-hot class vector {R, IARITH, ILOGIC, LW, SW, BEQ, BNE, J, ILLEGAL} plus the extend mode. It is instantiated once, on the current opcode.

Test Plan:
- Zero-wait memory, op 0x23 (lw) → state_o sequence 0,1,2,3,4,0:
  - extend_o = 1 in ID through WB;
  - reg_write_o = 1 and mem_to_reg_o = 1 only in WB;
  - retired_o goes 0 → 1.
- op 0x0D (ori) → extend_o = 0, alu_src_o = 1 and alu_op_o = 11 in EX; WB with reg_dst_o = 0; 4 cycles total.
- op 0x04 (beq) with zero_i = 1, then op 0x05 (bne) with zero_i = 1:
  - beq: pc_write_o = 1, pc_src_o = 01 in EX.
  - bne: pc_write_o = 0 in EX.
  - Both return to IF; retired_o += 2.
- op 0x2B (sw) with mem_ready_i low for 3 MEM cycles → mem_req_o = 1 and mem_we_o = 1 held for 4 cycles, then IF; reg_write_o is never 1.
- op 0x3F → illegal_o = 1 for exactly one cycle in ID, next state IF, retired_o unchanged.
- rst_i driven low in WB of an R-type → reg_write_o falls to 0 immediately and state_o = 0; retired_o = 0 after reset. Preload retired_o to all-ones and retire one instruction → wraps to 0.
